// File: rtl/sigmoid_fp16_arbiter.sv
// Round-robin front end sharing one fixed-latency fp16 sigmoid core among NUM_REQ requesters.
// Each issued operand carries its requester id down a tag pipe that matches the core latency;
// results land in an in-order FIFO whose space is reserved by credits at issue time.
module sigmoid_fp16_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [15:0]            rsp_data,
  output logic                   pe_ivalid,
  output logic [15:0]            pe_datain,
  input  logic [15:0]            pe_dataout
);
  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [IdW-1:0]     last;
  logic [IdW-1:0]     winner;
  logic [IdW-1:0]     cand;
  logic               found;
  logic               credit_ok;
  logic               accept;
  logic [IdW-1:0]     issue_id;
  logic [LATENCY-1:0] tag_valid;
  logic [IdW-1:0]     tag_id [LATENCY];
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [CntW-1:0]    occ;
  logic [CntW-1:0]    inflight;
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [IdW-1:0]     fifo_id   [FIFO_DEPTH];
  logic [15:0]        fifo_data [FIFO_DEPTH];
  logic [IdW-1:0]     head_id;

  // Every accepted operand owns a FIFO slot from issue until it is popped.
  assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < (CntW + 1)'(FIFO_DEPTH);
  // Gated by resetn so req_ready is held low while reset is asserted.
  assign accept    = found & credit_ok & resetn;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = IdW'((int'(last) + k) % int'(NUM_REQ));
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // One-hot grant, combinational from req_valid.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Issue stage: register the winning operand and its id toward the core.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last      <= IdW'(NUM_REQ - 1);
      pe_ivalid <= 1'b0;
      pe_datain <= '0;
      issue_id  <= '0;
    end else begin
      pe_ivalid <= accept;
      if (accept) begin
        last      <= winner;
        pe_datain <= req_data[{winner, 4'b0000} +: 16];
        issue_id  <= winner;
      end
    end
  end

  // Tag pipe runs in lockstep with the core; it never stalls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_valid <= '0;
      for (int k = 0; k < int'(LATENCY); k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_valid[0] <= pe_ivalid;
      tag_id[0]    <= issue_id;
      for (int k = 1; k < int'(LATENCY); k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  assign push       = tag_valid[LATENCY-1];
  assign fifo_empty = (occ == '0);
  assign head_id    = fifo_id[rd_ptr];
  assign pop        = |(rsp_valid & rsp_ready);
  // Zero when empty so outputs stay quiet until the first capture.
  assign rsp_data   = fifo_empty ? 16'h0000 : fifo_data[rd_ptr];

  // Route the head result to its owner only; later results wait behind it.
  always_comb begin
    rsp_valid = '0;
    if (!fifo_empty) begin
      rsp_valid[head_id] = 1'b1;
    end
  end

  // Result storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_id[wr_ptr]   <= tag_id[LATENCY-1];
      fifo_data[wr_ptr] <= pe_dataout;
    end
  end

  // FIFO pointers and the two credit counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CntW'(1);
        2'b01:   occ <= occ - CntW'(1);
        default: occ <= occ;
      endcase
      case ({accept, push})
        2'b10:   inflight <= inflight + CntW'(1);
        2'b01:   inflight <= inflight - CntW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Credits reserve a slot for each in-flight result, so a push into a full FIFO is a bug.
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && occ == CntW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_sigmoid_fp16_arbiter.sv
// Bench for sigmoid_fp16_arbiter: directed scenarios plus randomized traffic, checked against a
// transaction-level model (outstanding count, in-order result queue with arrival times).
module tb_sigmoid_fp16_arbiter;
  localparam int NR    = 4;
  localparam int LAT_A = 5;
  localparam int DEP_A = 8;
  localparam int LAT_B = 8;
  localparam int DEP_B = 16;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_data;
  logic [15:0] rsp_data, pe_datain, pe_dataout;
  logic        pe_ivalid;
  logic [3:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [63:0] b_req_data;
  logic [15:0] b_rsp_data, b_pe_datain, b_pe_dataout;
  logic        b_pe_ivalid;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sigmoid_fp16_arbiter #(.NUM_REQ(NR), .LATENCY(LAT_A), .FIFO_DEPTH(DEP_A)) dut_a (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .pe_ivalid(pe_ivalid), .pe_datain(pe_datain), .pe_dataout(pe_dataout));

  sigmoid_fp16_arbiter #(.NUM_REQ(NR), .LATENCY(LAT_B), .FIFO_DEPTH(DEP_B)) dut_b (
    .clock(clock), .resetn(resetn), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .pe_ivalid(b_pe_ivalid), .pe_datain(b_pe_datain),
    .pe_dataout(b_pe_dataout));

  // Stand-in for the sigmoid core: any fixed function works; 0 maps to 0x3800 like sigmoid(0).
  function automatic logic [15:0] core_fn(input logic [15:0] x);
    logic [15:0] p;
    p = x * 16'd40503;
    return p ^ 16'h3800;
  endfunction

  function automatic logic [15:0] lane_of(input logic [63:0] d, input int i);
    logic [63:0] t;
    t = d >> (16 * i);
    return t[15:0];
  endfunction

  // Fixed-latency core models, never stalled.
  logic [15:0] core_a [LAT_A];
  logic [15:0] core_b [LAT_B];
  always @(posedge clock) begin
    for (int k = LAT_A - 1; k > 0; k--) core_a[k] <= core_a[k-1];
    core_a[0] <= core_fn(pe_datain);
    for (int k = LAT_B - 1; k > 0; k--) core_b[k] <= core_b[k-1];
    core_b[0] <= core_fn(b_pe_datain);
  end
  assign pe_dataout   = core_a[LAT_A-1];
  assign b_pe_dataout = core_b[LAT_B-1];

  // Reference model for instance A.
  typedef struct {
    int          id;
    logic [15:0] data;
    int          arrive;
  } resp_t;
  resp_t       m_q[$];
  resp_t       m_r;
  int          m_last = NR - 1;
  int          m_out  = 0;
  logic        m_pe_valid = 1'b0;
  logic [15:0] m_pe_data  = 16'h0000;
  logic [3:0]  m_g, m_p;

  function automatic logic [3:0] exp_ready();
    if (!resetn || m_out >= DEP_A) return 4'b0000;
    for (int k = 1; k <= NR; k++) begin
      if (req_valid[(m_last + k) % NR]) return 4'b0001 << ((m_last + k) % NR);
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] exp_rsp_valid();
    if (m_q.size() != 0 && m_q[0].arrive <= cyc) return 4'b0001 << m_q[0].id;
    return 4'b0000;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_last = NR - 1;
      m_out = 0;
      m_q.delete();
      m_pe_valid = 1'b0;
      m_pe_data = 16'h0000;
    end else begin
      m_g = exp_ready();
      m_p = exp_rsp_valid() & rsp_ready;
      if (m_p != 4'b0000) begin
        m_q.delete(0);
        m_out--;
      end
      m_pe_valid = (m_g != 4'b0000);
      for (int i = 0; i < NR; i++) begin
        if (m_g[i]) begin
          m_last = i;
          m_pe_data = lane_of(req_data, i);
          m_r.id = i;
          m_r.data = core_fn(lane_of(req_data, i));
          m_r.arrive = cyc + LAT_A + 2;
          m_q.push_back(m_r);
          m_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '1; req_data = {$urandom, $urandom}; rsp_ready = '1;
    b_req_valid = '0; b_req_data = '0; b_rsp_ready = '1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else n_pass++;
    n_checks++; if (pe_ivalid !== 1'b0) $display("FAIL reset_pe_ivalid got %b exp 0", pe_ivalid); else n_pass++;
    n_checks++; if (pe_datain !== 16'h0) $display("FAIL reset_pe_datain got %h exp 0000", pe_datain); else n_pass++;
    n_checks++; if (rsp_data !== 16'h0) $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); else n_pass++;
    req_valid = '0;
    @(posedge clock); #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat;
    req_data = {$urandom, $urandom}; req_data[47:32] = 16'h0000;
    req_valid = 4'b0100; rsp_ready = 4'b0000;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant got %b exp 0100", req_ready); else n_pass++;
    tick();
    req_valid = 4'b0000;
    n_checks++; if (pe_ivalid !== 1'b1 || pe_datain !== 16'h0) $display("FAIL single_issue got %b/%h exp 1/0000", pe_ivalid, pe_datain); else n_pass++;
    lat = 0;
    while (rsp_valid === 4'b0000 && lat < 20) begin tick(); lat++; end
    n_checks++; if (lat !== 6) $display("FAIL single_latency got %0d exp 6", lat); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 16'h3800) $display("FAIL single_rsp_data got %h exp 3800", rsp_data); else n_pass++;
    rsp_ready = 4'b0100;
    tick();
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL single_pop got %b exp 0000", rsp_valid); else n_pass++;
    rsp_ready = 4'b0000;
  endtask

  task automatic test_round_robin();
    int prev = -1;
    req_valid = '1; rsp_ready = '1;
    for (int c = 0; c < 40; c++) begin
      req_data = {$urandom, $urandom};
      @(negedge clock);
      n_checks++; if (req_ready !== exp_ready()) $display("FAIL rr_ready got %b exp %b", req_ready, exp_ready()); else n_pass++;
      n_checks++; if (rsp_valid !== exp_rsp_valid()) $display("FAIL rr_rsp_valid got %b exp %b", rsp_valid, exp_rsp_valid()); else n_pass++;
      if (exp_rsp_valid() != 4'b0000) begin
        n_checks++; if (rsp_data !== m_q[0].data) $display("FAIL rr_rsp_data got %h exp %h", rsp_data, m_q[0].data); else n_pass++;
      end
      n_checks++; if (pe_ivalid !== m_pe_valid || pe_datain !== m_pe_data) $display("FAIL rr_issue got %b/%h exp %b/%h", pe_ivalid, pe_datain, m_pe_valid, m_pe_data); else n_pass++;
      if (prev >= 0) begin
        n_checks++; if (req_ready !== (4'b0001 << ((prev + 1) % NR))) $display("FAIL rr_rotation got %b exp %b", req_ready, 4'b0001 << ((prev + 1) % NR)); else n_pass++;
      end
      for (int i = 0; i < NR; i++) if (req_ready[i]) prev = i;
      tick();
    end
    req_valid = '0;
    repeat (12) tick();
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    rsp_ready = '0; req_valid = '1;
    for (int c = 0; c < 20; c++) begin
      req_data = {$urandom, $urandom};
      @(negedge clock);
      n_checks++; if (req_ready !== exp_ready()) $display("FAIL bp_ready got %b exp %b", req_ready, exp_ready()); else n_pass++;
      if (req_ready !== 4'b0000) accepts++;
      tick();
    end
    n_checks++; if (accepts !== DEP_A) $display("FAIL bp_accepts got %0d exp %0d", accepts, DEP_A); else n_pass++;
    rsp_ready = '1;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_pop_same_cycle got %b exp 0000", req_ready); else n_pass++;
    tick();
    rsp_ready = '0;
    @(negedge clock);
    n_checks++; if (!$onehot(req_ready)) $display("FAIL bp_one_accept got %b exp one-hot", req_ready); else n_pass++;
    tick();
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_refull got %b exp 0000", req_ready); else n_pass++;
    req_valid = '0; rsp_ready = '1;
    repeat (20) tick();
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL bp_drained got %b exp 0000", rsp_valid); else n_pass++;
  endtask

  task automatic test_hol();
    rsp_ready = 4'b1000; req_data = {$urandom, $urandom};
    req_valid = 4'b0010;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL hol_grant1 got %b exp 0010", req_ready); else n_pass++;
    tick();
    req_valid = 4'b1000;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL hol_grant3 got %b exp 1000", req_ready); else n_pass++;
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      n_checks++; if (rsp_valid !== exp_rsp_valid() || rsp_valid === 4'b1000) $display("FAIL hol_wait got %b exp %b", rsp_valid, exp_rsp_valid()); else n_pass++;
      tick();
    end
    n_checks++; if (rsp_valid !== 4'b0010) $display("FAIL hol_blocked got %b exp 0010", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== core_fn(req_data[31:16])) $display("FAIL hol_data got %h exp %h", rsp_data, core_fn(req_data[31:16])); else n_pass++;
    rsp_ready = 4'b1010;
    tick();
    n_checks++; if (rsp_valid !== 4'b1000) $display("FAIL hol_next got %b exp 1000", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== core_fn(req_data[63:48])) $display("FAIL hol_data3 got %h exp %h", rsp_data, core_fn(req_data[63:48])); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL hol_empty got %b exp 0000", rsp_valid); else n_pass++;
    rsp_ready = '1;
  endtask

  task automatic test_reset_midflight();
    int lat;
    logic [15:0] x;
    req_valid = '1; rsp_ready = '1;
    repeat (4) begin req_data = {$urandom, $urandom}; tick(); end
    req_valid = '0;
    repeat (3) tick();
    n_checks++; if (rsp_valid !== exp_rsp_valid() || rsp_valid === 4'b0000) $display("FAIL mid_before got %b exp %b", rsp_valid, exp_rsp_valid()); else n_pass++;
    req_valid = '1;
    resetn = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || pe_ivalid !== 1'b0 || pe_datain !== 16'h0 || rsp_data !== 16'h0)
      $display("FAIL mid_reset_outputs got %b/%b/%b/%h/%h exp all zero", req_ready, rsp_valid, pe_ivalid, pe_datain, rsp_data); else n_pass++;
    repeat (2) @(posedge clock);
    #1;
    req_valid = '0;
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL mid_stale got %b exp 0000", rsp_valid); else n_pass++;
      tick();
    end
    req_data = {$urandom, $urandom}; x = req_data[15:0];
    req_valid = '1;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got %b exp 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    lat = 0;
    while (rsp_valid === 4'b0000 && lat < 20) begin tick(); lat++; end
    n_checks++; if (lat !== 6) $display("FAIL mid_latency got %0d exp 6", lat); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0001 || rsp_data !== core_fn(x)) $display("FAIL mid_rsp got %b/%h exp 0001/%h", rsp_valid, rsp_data, core_fn(x)); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0) ? 4'($urandom) : 4'b1111;
      req_data = {$urandom, $urandom};
      @(negedge clock);
      n_checks++; if (req_ready !== exp_ready()) $display("FAIL rand_ready got %b exp %b", req_ready, exp_ready()); else n_pass++;
      n_checks++; if (rsp_valid !== exp_rsp_valid()) $display("FAIL rand_rsp_valid got %b exp %b", rsp_valid, exp_rsp_valid()); else n_pass++;
      if (exp_rsp_valid() != 4'b0000) begin
        n_checks++; if (rsp_data !== m_q[0].data) $display("FAIL rand_rsp_data got %h exp %h", rsp_data, m_q[0].data); else n_pass++;
      end
      n_checks++; if (pe_ivalid !== m_pe_valid || pe_datain !== m_pe_data) $display("FAIL rand_issue got %b/%h exp %b/%h", pe_ivalid, pe_datain, m_pe_valid, m_pe_data); else n_pass++;
      tick();
    end
    req_valid = '0; rsp_ready = '1;
    repeat (20) tick();
  endtask

  task automatic test_s10();
    int          sent = 0;
    int          got  = 0;
    int          acc_edge[$];
    logic [15:0] exp_d[$];
    b_rsp_ready = '1; b_req_data = '0;
    for (int c = 0; c < 400 && got < 256; c++) begin
      b_req_valid = (sent < 256) ? 4'b0010 : 4'b0000;
      b_req_data[31:16] = 16'(sent);
      @(negedge clock);
      n_checks++; if (b_req_ready !== b_req_valid) $display("FAIL s10_ready got %b exp %b", b_req_ready, b_req_valid); else n_pass++;
      if (b_rsp_valid !== 4'b0000) begin
        if (exp_d.size() == 0) begin
          n_checks++; $display("FAIL s10_unexpected got %b exp 0000", b_rsp_valid);
        end else begin
          n_checks++; if (b_rsp_valid !== 4'b0010) $display("FAIL s10_rsp_valid got %b exp 0010", b_rsp_valid); else n_pass++;
          n_checks++; if (b_rsp_data !== exp_d[0]) $display("FAIL s10_rsp_data got %h exp %h", b_rsp_data, exp_d[0]); else n_pass++;
          n_checks++; if (cyc - acc_edge[0] !== LAT_B + 1) $display("FAIL s10_latency got %0d exp %0d", cyc - acc_edge[0], LAT_B + 1); else n_pass++;
          exp_d.delete(0); acc_edge.delete(0); got++;
        end
      end
      if (b_req_ready[1] === 1'b1) begin
        acc_edge.push_back(cyc + 1);
        exp_d.push_back(core_fn(16'(sent)));
        sent++;
      end
      tick();
    end
    b_req_valid = '0;
    n_checks++; if (got !== 256) $display("FAIL s10_count got %0d exp 256", got); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hol();
    test_reset_midflight();
    test_random();
    test_s10();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
